vga_buf_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_buf_arbiter.sv | 146 ++++++++++++++
 tb/tb_vga_buf_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA screen-buffer constants and the fill-engine state/grant encodings.
`timescale 1ns/1ps
package vga_pkg;

    localparam int H_TILES     = 80;
    localparam int V_TILES     = 30;
    localparam int SINGLE_DATA = 7;
    localparam int STRB_WIDTH  = 4;
    localparam int NUM_ADDRS   = (H_TILES * V_TILES) / STRB_WIDTH;
    localparam int ADDR_WIDTH  = 10;
    localparam int DATA_WIDTH  = SINGLE_DATA * STRB_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_FINISH = 2'd2
    } fill_state_e;

    typedef enum logic {
        GR_AXI  = 1'b0,
        GR_FILL = 1'b1
    } grant_e;

endpackage

// File: rtl/vga_buf_arbiter.sv
// Screen-buffer write-port arbiter: shares the single write port between the
// AXI-lite write path and a range fill engine with round-robin on conflict.
`timescale 1ns/1ps
module vga_buf_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_ADDRS   = vga_pkg::NUM_ADDRS,
    parameter int ADDR_WIDTH  = vga_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = vga_pkg::DATA_WIDTH,
    parameter int SINGLE_DATA = vga_pkg::SINGLE_DATA,
    parameter int STRB_WIDTH  = vga_pkg::STRB_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   axi_wr_valid_i,
    output logic                   axi_wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]  axi_wr_addr_i,
    input  logic [STRB_WIDTH-1:0]  axi_wr_strb_i,
    input  logic [DATA_WIDTH-1:0]  axi_wr_data_i,
    input  logic                   fill_start_i,
    input  logic                   fill_abort_i,
    input  logic [ADDR_WIDTH-1:0]  fill_first_i,
    input  logic [ADDR_WIDTH-1:0]  fill_last_i,
    input  logic [SINGLE_DATA-1:0] fill_char_i,
    output logic                   fill_busy_o,
    output logic                   fill_done_o,
    output logic                   fill_err_o,
    output logic                   wr_en_o,
    output logic [ADDR_WIDTH-1:0]  w_addr_o,
    output logic [STRB_WIDTH-1:0]  w_strb_o,
    output logic [DATA_WIDTH-1:0]  din_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_LEGAL = ADDR_WIDTH'(NUM_ADDRS - 1);

    fill_state_e            state_reg, state_next;
    grant_e                 last_grant_reg, last_grant_next;
    logic [ADDR_WIDTH-1:0]  ptr_reg, ptr_next;
    logic [ADDR_WIDTH-1:0]  last_reg, last_next;
    logic [SINGLE_DATA-1:0] char_reg, char_next;
    logic                   err_next;
    logic                   grant_axi, grant_fill, range_ok;

    logic                   wr_en_reg, busy_reg, done_reg, err_reg;
    logic [ADDR_WIDTH-1:0]  w_addr_reg;
    logic [STRB_WIDTH-1:0]  w_strb_reg;
    logic [DATA_WIDTH-1:0]  din_reg;

    assign range_ok = (fill_first_i <= fill_last_i) && (fill_last_i <= LAST_LEGAL);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        ptr_next        = ptr_reg;
        last_next       = last_reg;
        char_next       = char_reg;
        err_next        = 1'b0;
        grant_axi       = 1'b0;
        grant_fill      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                grant_axi = axi_wr_valid_i;
                if (fill_start_i) begin
                    if (range_ok) begin
                        ptr_next   = fill_first_i;
                        last_next  = fill_last_i;
                        char_next  = fill_char_i;
                        state_next = ST_FILL;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                // The fill engine always requests here, so AXI only wins
                // when the previous contested slot went to the fill.
                if (axi_wr_valid_i && (last_grant_reg == GR_FILL)) begin
                    grant_axi       = 1'b1;
                    last_grant_next = GR_AXI;
                end else begin
                    grant_fill      = 1'b1;
                    last_grant_next = GR_FILL;
                    ptr_next        = ptr_reg + ADDR_WIDTH'(1);
                end
                if ((grant_fill && (ptr_reg == last_reg)) || fill_abort_i) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                grant_axi  = axi_wr_valid_i;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GR_FILL;
            ptr_reg        <= '0;
            last_reg       <= '0;
            char_reg       <= '0;
            wr_en_reg      <= 1'b0;
            w_addr_reg     <= '0;
            w_strb_reg     <= '0;
            din_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            ptr_reg        <= ptr_next;
            last_reg       <= last_next;
            char_reg       <= char_next;
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_FINISH);
            err_reg        <= err_next;
            wr_en_reg      <= grant_axi | grant_fill;
            if (grant_axi) begin
                w_addr_reg <= axi_wr_addr_i;
                w_strb_reg <= axi_wr_strb_i;
                din_reg    <= axi_wr_data_i;
            end else if (grant_fill) begin
                w_addr_reg <= ptr_reg;
                w_strb_reg <= {STRB_WIDTH{1'b1}};
                din_reg    <= DATA_WIDTH'({STRB_WIDTH{char_reg}});
            end else begin
                w_addr_reg <= '0;
                w_strb_reg <= '0;
                din_reg    <= '0;
            end
        end
    end

    assign axi_wr_ready_o = axi_wr_valid_i & grant_axi;
    assign fill_busy_o    = busy_reg;
    assign fill_done_o    = done_reg;
    assign fill_err_o     = err_reg;
    assign wr_en_o        = wr_en_reg;
    assign w_addr_o       = w_addr_reg;
    assign w_strb_o       = w_strb_reg;
    assign din_o          = din_reg;

endmodule

// File: tb/tb_vga_buf_arbiter.sv
// Directed bench for vga_buf_arbiter: AXI pass-through, full and contended
// fills, illegal ranges, abort and mid-fill reset.
`timescale 1ns/1ps
module tb_vga_buf_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        axi_wr_valid_i = 1'b0;
    logic        axi_wr_ready_o;
    logic [9:0]  axi_wr_addr_i = '0;
    logic [3:0]  axi_wr_strb_i = '0;
    logic [27:0] axi_wr_data_i = '0;
    logic        fill_start_i = 1'b0;
    logic        fill_abort_i = 1'b0;
    logic [9:0]  fill_first_i = '0;
    logic [9:0]  fill_last_i = '0;
    logic [6:0]  fill_char_i = '0;
    logic        fill_busy_o, fill_done_o, fill_err_o;
    logic        wr_en_o;
    logic [9:0]  w_addr_o;
    logic [3:0]  w_strb_o;
    logic [27:0] din_o;

    int checks = 0;
    int errors = 0;
    int ax;

    vga_buf_arbiter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .axi_wr_valid_i (axi_wr_valid_i),
        .axi_wr_ready_o (axi_wr_ready_o),
        .axi_wr_addr_i  (axi_wr_addr_i),
        .axi_wr_strb_i  (axi_wr_strb_i),
        .axi_wr_data_i  (axi_wr_data_i),
        .fill_start_i   (fill_start_i),
        .fill_abort_i   (fill_abort_i),
        .fill_first_i   (fill_first_i),
        .fill_last_i    (fill_last_i),
        .fill_char_i    (fill_char_i),
        .fill_busy_o    (fill_busy_o),
        .fill_done_o    (fill_done_o),
        .fill_err_o     (fill_err_o),
        .wr_en_o        (wr_en_o),
        .w_addr_o       (w_addr_o),
        .w_strb_o       (w_strb_o),
        .din_o          (din_o)
    );

    always #20 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick;
        tick;
        check("rst_wr_en", 32'(wr_en_o), 32'd0);
        check("rst_addr", 32'(w_addr_o), 32'd0);
        check("rst_strb", 32'(w_strb_o), 32'd0);
        check("rst_din", 32'(din_o), 32'd0);
        check("rst_busy", 32'(fill_busy_o), 32'd0);
        check("rst_done", 32'(fill_done_o), 32'd0);
        check("rst_err", 32'(fill_err_o), 32'd0);
        check("rst_ready", 32'(axi_wr_ready_o), 32'd0);
        rst_i = 1'b0;
        tick;

        // Single AXI write with no fill running
        axi_wr_valid_i = 1'b1;
        axi_wr_addr_i  = 10'd5;
        axi_wr_strb_i  = 4'hF;
        axi_wr_data_i  = 28'h0ABCDEF;
        #1;
        check("axi_ready", 32'(axi_wr_ready_o), 32'd1);
        tick;
        axi_wr_valid_i = 1'b0;
        check("axi_wr", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'd5}));
        check("axi_strb", 32'(w_strb_o), 32'hF);
        check("axi_din", 32'(din_o), 32'h0ABCDEF);
        tick;
        check("axi_wr_off", 32'(wr_en_o), 32'd0);

        // Full-screen clear with spaces, no AXI traffic
        fill_first_i = 10'd0;
        fill_last_i  = 10'd599;
        fill_char_i  = 7'h20;
        fill_start_i = 1'b1;
        tick;
        fill_start_i = 1'b0;
        check("full_busy_start", 32'(fill_busy_o), 32'd1);
        check("full_no_wr_yet", 32'(wr_en_o), 32'd0);
        for (int i = 0; i < 600; i++) begin
            tick;
            check("full_wr", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'(i)}));
            check("full_din", 32'(din_o), 32'h4081020);
            check("full_done", 32'(fill_done_o), (i == 599) ? 32'd1 : 32'd0);
            check("full_busy", 32'(fill_busy_o), 32'd1);
        end
        tick;
        check("full_end_done", 32'(fill_done_o), 32'd0);
        check("full_end_busy", 32'(fill_busy_o), 32'd0);
        check("full_end_wr", 32'(wr_en_o), 32'd0);

        // Contended fill 10..19 with AXI valid every cycle
        fill_first_i = 10'd10;
        fill_last_i  = 10'd19;
        fill_char_i  = 7'h41;
        fill_start_i = 1'b1;
        tick;
        fill_start_i = 1'b0;
        check("cont_busy", 32'(fill_busy_o), 32'd1);
        ax = 0;
        for (int j = 0; j < 20; j++) begin
            axi_wr_valid_i = 1'b1;
            axi_wr_addr_i  = 10'(100 + ax);
            axi_wr_strb_i  = 4'h3;
            axi_wr_data_i  = 28'h1000000 + 28'(ax);
            #1;
            check("cont_ready", 32'(axi_wr_ready_o), (j % 2 == 0) ? 32'd1 : 32'd0);
            tick;
            if (j % 2 == 0) begin
                check("cont_axi_wr", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'(100 + ax)}));
                check("cont_axi_din", 32'(din_o), 32'h1000000 + 32'(ax));
                check("cont_axi_strb", 32'(w_strb_o), 32'h3);
                ax++;
            end else begin
                check("cont_fill_wr", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'(10 + j / 2)}));
                check("cont_fill_din", 32'(din_o), 32'({4{7'h41}}));
                check("cont_fill_strb", 32'(w_strb_o), 32'hF);
            end
            check("cont_done", 32'(fill_done_o), (j == 19) ? 32'd1 : 32'd0);
        end
        axi_wr_addr_i = 10'(100 + ax);
        axi_wr_data_i = 28'h1000000 + 28'(ax);
        #1;
        check("cont_finish_ready", 32'(axi_wr_ready_o), 32'd1);
        tick;
        axi_wr_valid_i = 1'b0;
        check("cont_finish_axi", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'(100 + ax)}));
        tick;
        check("cont_end_busy", 32'(fill_busy_o), 32'd0);
        check("cont_end_wr", 32'(wr_en_o), 32'd0);

        // Illegal ranges: first > last, then last beyond the buffer
        fill_first_i = 10'd20;
        fill_last_i  = 10'd10;
        fill_start_i = 1'b1;
        tick;
        fill_start_i = 1'b0;
        check("ill1_err", 32'(fill_err_o), 32'd1);
        check("ill1_busy", 32'(fill_busy_o), 32'd0);
        check("ill1_wr", 32'(wr_en_o), 32'd0);
        tick;
        check("ill1_err_pulse", 32'(fill_err_o), 32'd0);
        check("ill1_wr2", 32'(wr_en_o), 32'd0);
        fill_first_i = 10'd0;
        fill_last_i  = 10'd600;
        fill_start_i = 1'b1;
        tick;
        fill_start_i = 1'b0;
        check("ill2_err", 32'(fill_err_o), 32'd1);
        check("ill2_busy", 32'(fill_busy_o), 32'd0);
        check("ill2_wr", 32'(wr_en_o), 32'd0);
        tick;
        check("ill2_err_pulse", 32'(fill_err_o), 32'd0);
        check("ill2_busy2", 32'(fill_busy_o), 32'd0);
        check("ill2_wr2", 32'(wr_en_o), 32'd0);

        // Abort during the fifth fill grant
        fill_first_i = 10'd0;
        fill_last_i  = 10'd99;
        fill_char_i  = 7'h30;
        fill_start_i = 1'b1;
        tick;
        fill_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("abort_wr", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'(i)}));
            check("abort_done_early", 32'(fill_done_o), 32'd0);
        end
        fill_abort_i = 1'b1;
        tick;
        fill_abort_i = 1'b0;
        check("abort_last_wr", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'd4}));
        check("abort_done", 32'(fill_done_o), 32'd1);
        tick;
        check("abort_after_wr", 32'(wr_en_o), 32'd0);
        check("abort_after_done", 32'(fill_done_o), 32'd0);
        check("abort_after_busy", 32'(fill_busy_o), 32'd0);
        tick;
        check("abort_idle_wr", 32'(wr_en_o), 32'd0);

        // Reset in the middle of a fill, then a fresh fill
        fill_start_i = 1'b1;
        tick;
        fill_start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("mrst_wr", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'(i)}));
        end
        rst_i = 1'b1;
        #1;
        check("mrst_wr_off", 32'(wr_en_o), 32'd0);
        check("mrst_addr", 32'(w_addr_o), 32'd0);
        check("mrst_din", 32'(din_o), 32'd0);
        check("mrst_busy", 32'(fill_busy_o), 32'd0);
        check("mrst_done", 32'(fill_done_o), 32'd0);
        tick;
        rst_i = 1'b0;
        tick;
        check("mrst_no_done", 32'(fill_done_o), 32'd0);
        check("mrst_no_wr", 32'(wr_en_o), 32'd0);
        fill_first_i = 10'd50;
        fill_last_i  = 10'd51;
        fill_char_i  = 7'h55;
        fill_start_i = 1'b1;
        tick;
        fill_start_i = 1'b0;
        check("post_busy", 32'(fill_busy_o), 32'd1);
        tick;
        check("post_wr0", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'd50}));
        check("post_din", 32'(din_o), 32'({4{7'h55}}));
        check("post_done0", 32'(fill_done_o), 32'd0);
        tick;
        check("post_wr1", 32'({wr_en_o, w_addr_o}), 32'({1'b1, 10'd51}));
        check("post_done1", 32'(fill_done_o), 32'd1);
        tick;
        check("post_idle_busy", 32'(fill_busy_o), 32'd0);
        check("post_idle_wr", 32'(wr_en_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
